part2_button_debounce: RTL and testbench

Conditions the raw push-button inputs for the button PIO. It synchronizes each asynchronous key to `clk` and debounces it with a per-channel stability counter. It emits clean active-high "pressed" levels, which drive the PIO `in_port` directly, plus one-cycle press/release pulses and sticky press-event flags for software polling. It sits between the board key pins and the Avalon button PIO slave.

---
 rtl/part2_button_debounce.sv | 74 +++++++
 tb/tb_part2_button_debounce.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/part2_button_debounce.sv
// Push-button conditioner: per-channel 2-flop synchronizer, stability-counter debounce,
// registered pressed level, one-cycle press/release pulses and sticky press-event flags.
module part2_button_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int RAW_ACTIVE_LOW  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] key_raw,
    input  logic [WIDTH-1:0] event_clear,
    output logic [WIDTH-1:0] key_level,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] event_flags
);

    localparam logic             POL     = (RAW_ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] pressed_raw;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] cnt [WIDTH];

    assign pressed_raw = key_raw ^ {WIDTH{POL}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pressed_raw;
            s2 <= s1;
        end
    end

    // Level, pulses and flags share one update so pulses coincide with the new level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_level     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            event_flags   <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                press_pulse[i]   <= 1'b0;
                release_pulse[i] <= 1'b0;
                if (s2[i] == key_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    cnt[i]           <= '0;
                    key_level[i]     <= s2[i];
                    press_pulse[i]   <= s2[i];
                    release_pulse[i] <= ~s2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end

                // A press accepted on the same edge as a clear keeps the flag set.
                if ((s2[i] != key_level[i]) && (cnt[i] == CNT_MAX) && s2[i]) begin
                    event_flags[i] <= 1'b1;
                end else if (event_clear[i]) begin
                    event_flags[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_part2_button_debounce.sv
// Directed bench for part2_button_debounce with DEBOUNCE_CYCLES=8, active-low keys;
// expected output snapshots are queued at stimulus time and checked as the DUT responds.
module tb_part2_button_debounce;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] key_raw;
    logic [3:0] event_clear;
    logic [3:0] key_level;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] event_flags;

    int n_pass  = 0;
    int n_total = 0;
    int unsigned npress [4] = '{0, 0, 0, 0};

    typedef struct {
        string      tag;
        logic [3:0] lvl;
        logic [3:0] pp;
        logic [3:0] rp;
        logic [3:0] fl;
    } exp_t;

    exp_t sb[$];

    part2_button_debounce #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(8),
        .CNT_W(16),
        .RAW_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .key_raw(key_raw),
        .event_clear(event_clear),
        .key_level(key_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .event_flags(event_flags)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (press_pulse[i] === 1'b1) npress[i]++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic push(input string tag, input logic [3:0] lvl, input logic [3:0] pp,
                        input logic [3:0] rp, input logic [3:0] fl);
        exp_t e;
        e.tag = tag;
        e.lvl = lvl;
        e.pp  = pp;
        e.rp  = rp;
        e.fl  = fl;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".level"},   key_level,     e.lvl);
            chk({e.tag, ".press"},   press_pulse,   e.pp);
            chk({e.tag, ".release"}, release_pulse, e.rp);
            chk({e.tag, ".flags"},   event_flags,   e.fl);
        end
    endtask

    initial begin
        int unsigned base1;

        reset_n     = 1'b0;
        key_raw     = 4'hF;
        event_clear = 4'h0;

        // Reset, then idle with all keys released
        push("in_reset", 4'h0, 4'h0, 4'h0, 4'h0);
        step(3);
        pop_check();
        reset_n = 1'b1;
        push("idle30", 4'h0, 4'h0, 4'h0, 4'h0);
        step(30);
        pop_check();
        chk("idle_press_count0", 4'(npress[0]), 4'd0);

        // Clean press on channel 0
        key_raw[0] = 1'b0;
        push("press0_e9", 4'h0, 4'h0, 4'h0, 4'h0);
        step(9);
        pop_check();
        push("press0_e10", 4'h1, 4'h1, 4'h0, 4'h1);
        step(1);
        pop_check();
        push("press0_e11", 4'h1, 4'h0, 4'h0, 4'h1);
        step(1);
        pop_check();

        // Bounce on channel 1: 3-cycle segments for 24 cycles, then held pressed
        base1 = npress[1];
        for (int k = 0; k < 8; k++) begin
            key_raw[1] = (k % 2 == 0) ? 1'b0 : 1'b1;
            push("bounce1", 4'h1, 4'h0, 4'h0, 4'h1);
            step(3);
            pop_check();
        end
        key_raw[1] = 1'b0;
        push("bounce1_e9", 4'h1, 4'h0, 4'h0, 4'h1);
        step(9);
        pop_check();
        push("bounce1_e10", 4'h3, 4'h2, 4'h0, 4'h3);
        step(1);
        pop_check();
        push("bounce1_e11", 4'h3, 4'h0, 4'h0, 4'h3);
        step(4);
        pop_check();
        chk("bounce1_one_pulse", 4'(npress[1] - base1), 4'd1);

        // Release channel 0, flag stays; then clear it
        key_raw[0] = 1'b1;
        push("release0_e9", 4'h3, 4'h0, 4'h0, 4'h3);
        step(9);
        pop_check();
        push("release0_e10", 4'h2, 4'h0, 4'h1, 4'h3);
        step(1);
        pop_check();
        push("release0_e11", 4'h2, 4'h0, 4'h0, 4'h3);
        step(1);
        pop_check();
        event_clear[0] = 1'b1;
        push("clear0", 4'h2, 4'h0, 4'h0, 4'h2);
        step(1);
        event_clear[0] = 1'b0;
        pop_check();

        // Set/clear collision on channel 2
        key_raw[2] = 1'b0;
        push("coll2_e9", 4'h2, 4'h0, 4'h0, 4'h2);
        step(9);
        pop_check();
        event_clear[2] = 1'b1;
        push("coll2_e10", 4'h6, 4'h4, 4'h0, 4'h6);
        step(1);
        event_clear[2] = 1'b0;
        pop_check();
        push("coll2_e11", 4'h6, 4'h0, 4'h0, 4'h6);
        step(1);
        pop_check();

        // Reset mid-count on channel 3; held keys re-accepted after full latency
        key_raw[3] = 1'b0;
        step(5);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        push("midreset_async", 4'h0, 4'h0, 4'h0, 4'h0);
        pop_check();
        step(2);
        reset_n = 1'b1;
        push("postreset_e9", 4'h0, 4'h0, 4'h0, 4'h0);
        step(9);
        pop_check();
        push("postreset_e10", 4'hE, 4'hE, 4'h0, 4'hE);
        step(1);
        pop_check();
        push("postreset_e11", 4'hE, 4'h0, 4'h0, 4'hE);
        step(1);
        pop_check();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
